// File: rtl/cond_pkg.sv
// Shared types for the ALU flag/writeback stage and the branch unit.
// Condition codes, NZCV bit positions and the writeback bundle.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'h0,
    NE = 4'h1,
    CS = 4'h2,
    CC = 4'h3,
    MI = 4'h4,
    PL = 4'h5,
    VS = 4'h6,
    VC = 4'h7,
    HI = 4'h8,
    LS = 4'h9,
    GE = 4'hA,
    LT = 4'hB,
    GT = 4'hC,
    LE = 4'hD,
    AL = 4'hE,
    NV = 4'hF
  } cond_code_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int DATA_W = 32;
  localparam int RD_W_DEF = 4;

  typedef struct packed {
    logic [DATA_W-1:0]   result;
    logic [RD_W_DEF-1:0] rd;
    logic                wr_en;
  } wb_op_t;

endpackage

// File: rtl/alu_flags_stage_if.sv
// Upstream op and writeback handshake bundle for alu_flags_stage.
// master drives ops and out_ready; slave is the stage.
interface alu_flags_stage_if #(
  parameter int N     = 32,
  parameter int RD_W  = 4,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_result;
  logic             in_neg;
  logic             in_zr;
  logic             in_cry;
  logic             in_of;
  logic             in_set_flags;
  logic [3:0]       in_cond;
  logic [RD_W-1:0]  in_rd;
  logic             in_wr_en;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_result;
  logic [RD_W-1:0]  out_rd;
  logic             out_wr_en;
  logic [3:0]       flags_nzcv;
  logic [CNT_W-1:0] squash_cnt;

  modport master (
    output in_valid, in_result, in_neg, in_zr,
    output in_cry, in_of, in_set_flags, in_cond,
    output in_rd, in_wr_en, out_ready,
    input  in_ready, out_valid, out_result,
    input  out_rd, out_wr_en, flags_nzcv, squash_cnt
  );

  modport slave (
    input  in_valid, in_result, in_neg, in_zr,
    input  in_cry, in_of, in_set_flags, in_cond,
    input  in_rd, in_wr_en, out_ready,
    output in_ready, out_valid, out_result,
    output out_rd, out_wr_en, flags_nzcv, squash_cnt
  );
endinterface

// File: rtl/cond_eval.sv
// ARM-style condition code check against an NZCV value.
// Purely combinational; shared with the branch unit.
module cond_eval
  import cond_pkg::*;
(
  input  cond_code_e cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  always_comb begin
    n    = nzcv[FLAG_N];
    z    = nzcv[FLAG_Z];
    c    = nzcv[FLAG_C];
    v    = nzcv[FLAG_V];
    pass = 1'b1;
    unique case (cond)
      EQ: pass = z;
      NE: pass = !z;
      CS: pass = c;
      CC: pass = !c;
      MI: pass = n;
      PL: pass = !n;
      VS: pass = v;
      VC: pass = !v;
      HI: pass = c && !z;
      LS: pass = !c || z;
      GE: pass = (n == v);
      LT: pass = (n != v);
      GT: pass = !z && (n == v);
      LE: pass = z || (n != v);
      AL: pass = 1'b1;
      NV: pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_flags_stage.sv
// Registers ALU results, owns NZCV, evaluates condition codes and
// gates writes of failed ops; 2-entry skid buffer on the output side.
module alu_flags_stage
  import cond_pkg::*;
#(
  parameter int N     = DATA_W,
  parameter int RD_W  = RD_W_DEF,
  parameter int CNT_W = 16
) (
  input logic         clk,
  input logic         rst,
  alu_flags_stage_if.slave bus
);

  wb_op_t           main_q;
  wb_op_t           skid_q;
  wb_op_t           new_op;
  logic             main_v;
  logic             skid_v;
  logic [3:0]       flags_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pass;
  logic             accept;
  logic             xfer;

  cond_eval u_cond (
    .cond (cond_code_e'(bus.in_cond)),
    .nzcv (flags_q),
    .pass (pass)
  );

  assign bus.in_ready   = !skid_v;
  assign bus.out_valid  = main_v;
  assign bus.out_result = main_q.result[N-1:0];
  assign bus.out_rd     = main_q.rd[RD_W-1:0];
  assign bus.out_wr_en  = main_q.wr_en;
  assign bus.flags_nzcv = flags_q;
  assign bus.squash_cnt = cnt_q;

  assign accept = bus.in_valid && !skid_v;
  assign xfer   = main_v && bus.out_ready;

  always_comb begin
    new_op        = '0;
    new_op.result = bus.in_result;
    new_op.rd     = bus.in_rd;
    new_op.wr_en  = bus.in_wr_en && pass;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q  <= '0;
      skid_q  <= '0;
      main_v  <= 1'b0;
      skid_v  <= 1'b0;
      flags_q <= 4'b0000;
      cnt_q   <= '0;
    end else begin
      // A full skid blocks accept, so only the drain path applies.
      if (skid_v) begin
        if (xfer) begin
          main_q <= skid_q;
          skid_v <= 1'b0;
        end
      end else if (accept) begin
        if (!main_v || xfer) begin
          main_q <= new_op;
          main_v <= 1'b1;
        end else begin
          skid_q <= new_op;
          skid_v <= 1'b1;
        end
      end else if (xfer) begin
        main_v <= 1'b0;
      end

      if (accept && pass && bus.in_set_flags) begin
        flags_q <= {bus.in_neg, bus.in_zr,
                    bus.in_cry, bus.in_of};
      end

      if (accept && !pass && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_flags_stage.sv
// Directed and randomized checks for alu_flags_stage (CNT_W=4).
// Expected values are hand-derived or come from a small queue model.
module tb_alu_flags_stage;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  alu_flags_stage_if #(.N(32), .RD_W(4), .CNT_W(4)) bus ();

  alu_flags_stage #(.N(32), .RD_W(4), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic [31:0] res,
                        input logic [3:0] nzcv,
                        input logic s,
                        input logic [3:0] cond,
                        input logic [3:0] rd,
                        input logic wr);
    bus.in_result    = res;
    bus.in_neg       = nzcv[3];
    bus.in_zr        = nzcv[2];
    bus.in_cry       = nzcv[1];
    bus.in_of        = nzcv[0];
    bus.in_set_flags = s;
    bus.in_cond      = cond;
    bus.in_rd        = rd;
    bus.in_wr_en     = wr;
  endtask

  task automatic send(input logic [31:0] res,
                      input logic [3:0] nzcv,
                      input logic s,
                      input logic [3:0] cond,
                      input logic [3:0] rd,
                      input logic wr);
    set_op(res, nzcv, s, cond, rd, wr);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50 && !bus.in_ready; i++)
      @(negedge clk);
    if (!bus.in_ready)
      chk("ready_timeout", bus.in_ready, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic expect_wb(input string tag, input logic wr);
    chk({tag, "_valid"}, bus.out_valid, 1);
    chk({tag, "_wr"}, bus.out_wr_en, wr);
  endtask

  function automatic logic cond_ok(input logic [3:0] c,
                                   input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy & !z;
      4'h9: return !cy | z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z & (n == v);
      4'hD: return z | (n != v);
      default: return 1'b1;
    endcase
  endfunction

  logic [36:0] q[$];
  logic [36:0] head;
  logic [3:0]  m_flags;
  logic [3:0]  m_cnt;
  logic        m_pass;
  logic        acc;
  logic        xf;
  int          sent;
  int          got;

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    set_op(32'h0, 4'h0, 1'b0, 4'hE, 4'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_flags", bus.flags_nzcv, 4'h0);
    chk("rst_squash", bus.squash_cnt, 4'h0);
    chk("rst_result", bus.out_result, 0);
    chk("rst_rd", bus.out_rd, 0);
    chk("rst_wr", bus.out_wr_en, 0);

    // fill main and skid, then reset mid-stream
    send(32'h11, 4'hF, 1'b1, 4'hE, 4'h1, 1'b1);
    send(32'h22, 4'hF, 1'b1, 4'hE, 4'h2, 1'b1);
    chk("full_in_ready", bus.in_ready, 0);
    chk("full_flags", bus.flags_nzcv, 4'hF);
    chk("full_result", bus.out_result, 32'h11);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_ready", bus.in_ready, 1);
    chk("mid_rst_flags", bus.flags_nzcv, 4'h0);
    chk("mid_rst_squash", bus.squash_cnt, 4'h0);
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("mid_rst_vanish", bus.out_valid, 0);

    // flag chain
    send(32'h0, 4'b0100, 1'b1, 4'hE, 4'h0, 1'b1);
    expect_wb("chain_a", 1);
    chk("chain_a_flags", bus.flags_nzcv, 4'b0100);
    send(32'h55, 4'h0, 1'b0, 4'h0, 4'h3, 1'b1);
    expect_wb("chain_eq", 1);
    chk("chain_eq_rd", bus.out_rd, 4'h3);
    chk("chain_eq_res", bus.out_result, 32'h55);
    send(32'h56, 4'h0, 1'b0, 4'h1, 4'h3, 1'b1);
    expect_wb("chain_ne", 0);
    chk("chain_ne_res", bus.out_result, 32'h56);
    chk("chain_ne_squash", bus.squash_cnt, 4'h1);

    // failed-condition S op leaves flags alone
    send(32'h1, 4'b1001, 1'b1, 4'hE, 4'h4, 1'b1);
    chk("set_1001", bus.flags_nzcv, 4'b1001);
    send(32'h2, 4'b0110, 1'b1, 4'hB, 4'h4, 1'b1);
    expect_wb("lt_fail", 0);
    chk("lt_fail_flags", bus.flags_nzcv, 4'b1001);
    chk("lt_fail_squash", bus.squash_cnt, 4'h2);

    // signed / unsigned compares
    send(32'h3, 4'h0, 1'b0, 4'hA, 4'h5, 1'b1);
    expect_wb("ge_1001", 1);
    send(32'h4, 4'h0, 1'b0, 4'hC, 4'h5, 1'b1);
    expect_wb("gt_1001", 1);
    send(32'h5, 4'h0, 1'b0, 4'hB, 4'h5, 1'b1);
    expect_wb("lt_1001", 0);
    send(32'h6, 4'b0001, 1'b1, 4'hE, 4'h6, 1'b1);
    chk("set_0001", bus.flags_nzcv, 4'b0001);
    send(32'h7, 4'h0, 1'b0, 4'hA, 4'h6, 1'b1);
    expect_wb("ge_0001", 0);
    send(32'h8, 4'h0, 1'b0, 4'hD, 4'h6, 1'b1);
    expect_wb("le_0001", 1);
    send(32'h9, 4'b0010, 1'b1, 4'hE, 4'h7, 1'b1);
    chk("set_0010", bus.flags_nzcv, 4'b0010);
    send(32'hA, 4'h0, 1'b0, 4'h8, 4'h7, 1'b1);
    expect_wb("hi_0010", 1);
    send(32'hB, 4'h0, 1'b0, 4'h9, 4'h7, 1'b1);
    expect_wb("ls_0010", 0);
    send(32'hC, 4'h0, 1'b0, 4'hF, 4'h7, 1'b1);
    expect_wb("nv_is_al", 1);
    chk("cmp_squash", bus.squash_cnt, 4'h5);

    // saturation: EQ fails with Z=0
    for (int i = 0; i < 5; i++)
      send(32'h100 + i, 4'h0, 1'b0, 4'h0, 4'h8, 1'b1);
    chk("sat_mid", bus.squash_cnt, 4'hA);
    for (int i = 0; i < 15; i++)
      send(32'h200 + i, 4'h0, 1'b0, 4'h0, 4'h8, 1'b1);
    chk("sat_top", bus.squash_cnt, 4'hF);
    expect_wb("sat_wr", 0);

    // backpressure
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    chk("bp_empty", bus.out_valid, 0);
    set_op(32'hA1, 4'h0, 1'b0, 4'hE, 4'h1, 1'b1);
    bus.in_valid = 1'b1;
    @(negedge clk) chk("bp_rdy1", bus.in_ready, 1);
    @(posedge clk);
    #1 set_op(32'hA2, 4'h0, 1'b0, 4'hE, 4'h2, 1'b1);
    @(negedge clk) chk("bp_rdy2", bus.in_ready, 1);
    chk("bp_out1", bus.out_result, 32'hA1);
    @(posedge clk);
    #1 set_op(32'hA3, 4'h0, 1'b0, 4'hE, 4'h3, 1'b1);
    @(negedge clk) chk("bp_rdy3", bus.in_ready, 0);
    @(posedge clk);
    @(negedge clk) chk("bp_hold_rdy", bus.in_ready, 0);
    chk("bp_hold_res", bus.out_result, 32'hA1);
    chk("bp_hold_rd", bus.out_rd, 4'h1);
    bus.out_ready = 1'b1;
    @(negedge clk) chk("bp_out2", bus.out_result, 32'hA2);
    chk("bp_rdy_back", bus.in_ready, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk) chk("bp_out3", bus.out_result, 32'hA3);
    chk("bp_out3_v", bus.out_valid, 1);
    @(negedge clk) chk("bp_drained", bus.out_valid, 0);

    // random traffic against a queue model
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_flags = 4'h0;
    m_cnt   = 4'h0;
    sent    = 0;
    got     = 0;
    set_op($urandom, 4'($urandom), 1'($urandom),
           4'($urandom), 4'($urandom), 1'($urandom));
    for (int cyc = 0; cyc < 20000 && sent < 2000; cyc++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      acc = bus.in_valid & bus.in_ready;
      xf  = bus.out_valid & bus.out_ready;
      if (xf) begin
        if (q.size() == 0) begin
          chk("rnd_extra_out", 1, 0);
        end else begin
          head = q.pop_front();
          chk("rnd_op", {bus.out_wr_en, bus.out_rd, bus.out_result}, head);
          got++;
        end
      end
      if (acc) begin
        m_pass = cond_ok(bus.in_cond, m_flags);
        q.push_back({bus.in_wr_en & m_pass, bus.in_rd, bus.in_result});
        if (m_pass && bus.in_set_flags)
          m_flags = {bus.in_neg, bus.in_zr, bus.in_cry, bus.in_of};
        if (!m_pass && m_cnt != 4'hF)
          m_cnt = m_cnt + 4'h1;
        sent++;
      end
      @(posedge clk);
      #1;
      if (acc)
        set_op($urandom, 4'($urandom), 1'($urandom),
               4'($urandom), 4'($urandom), 1'($urandom));
    end
    chk("rnd_sent", sent, 2000);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() != 0; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        head = q.pop_front();
        chk("rnd_drain", {bus.out_wr_en, bus.out_rd, bus.out_result}, head);
        got++;
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("rnd_empty", q.size(), 0);
    chk("rnd_got", got, 2000);
    chk("rnd_no_dup", bus.out_valid, 0);
    chk("rnd_flags", bus.flags_nzcv, m_flags);
    chk("rnd_squash", bus.squash_cnt, m_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
